// File: rtl/dmc_pkg.sv
// Shared definitions for the device memory controller: FSM encoding,
// command field layout and status register bit positions.
package dmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int unsigned CMD_ADDR_LSB = 0;

    localparam int unsigned SB_BUSY = 0;
    localparam int unsigned SB_DONE = 1;
    localparam int unsigned SB_ERR  = 2;
    localparam int unsigned SB_WRAP = 3;
    localparam int unsigned SB_NUM  = 4;

    // Length field starts right above the address field.
    function automatic int unsigned cmd_len_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

    // Op bit sits right above the length field.
    function automatic int unsigned cmd_op_bit(input int unsigned addr_w, input int unsigned len_w);
        return addr_w + len_w;
    endfunction

endpackage

// File: rtl/dmc_sram.sv
// Single-port synchronous RAM with registered read data and no reset.
module dmc_sram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/device_mem_ctrl.sv
// Device-side memory engine: block fill and block checksum over an internal
// RAM, driven by host strobes and reporting completion with a done pulse.
module device_mem_ctrl
    import dmc_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adreg_ld,
    input  logic              wdata_ld,
    input  logic              start,
    input  logic              sreg_en,
    input  logic              dreg_en,
    input  logic              clr,
    input  logic [DATA_W-1:0] host_data,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy
);

    localparam int unsigned LEN_LSB = cmd_len_lsb(ADDR_W);
    localparam int unsigned OP_BIT  = cmd_op_bit(ADDR_W, LEN_W);
    localparam int unsigned CMD_W   = OP_BIT + 1;

    state_e              state_q;
    logic                start_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [DATA_W-1:0]   fill_q;
    logic [DATA_W-1:0]   data_q;
    logic                busy_q;
    logic                done_q;
    logic                done_sticky_q;
    logic                err_q;
    logic                wrap_q;

    // Working copies so host register loads never disturb a transfer in flight.
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                op_q;
    logic [DATA_W-1:0]   wfill_q;
    logic [DATA_W-1:0]   acc_q;
    logic                rd_vld_q;

    logic                start_rise_c;
    logic                ram_we_c;
    logic [DATA_W-1:0]   ram_rdata;
    logic [DATA_W-1:0]   status_c;

    generate
        if (DATA_W > CMD_W) begin : g_unused_hi
            logic unused_host_hi;
            assign unused_host_hi = ^host_data[DATA_W-1:CMD_W];
        end
    endgenerate

    assign start_rise_c = start & ~start_q;
    assign ram_we_c     = (state_q == ST_XFER) && op_q;

    dmc_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (ram_we_c),
        .addr  (addr_q),
        .wdata (wfill_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            cmd_q         <= '0;
            fill_q        <= '0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_sticky_q <= 1'b0;
            err_q         <= 1'b0;
            wrap_q        <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            op_q          <= 1'b0;
            wfill_q       <= '0;
            acc_q         <= '0;
            rd_vld_q      <= 1'b0;
        end else begin
            start_q  <= start;
            done_q   <= 1'b0;
            rd_vld_q <= (state_q == ST_XFER);

            if (adreg_ld) begin
                cmd_q <= host_data[CMD_W-1:0];
            end
            if (wdata_ld) begin
                fill_q <= host_data;
            end

            // Clear first so a same-cycle set event below takes precedence.
            if (clr) begin
                done_sticky_q <= 1'b0;
                err_q         <= 1'b0;
                wrap_q        <= 1'b0;
            end
            if (state_q == ST_DONE) begin
                done_sticky_q <= 1'b1;
            end
            if (start_rise_c && (state_q != ST_IDLE)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_rise_c) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    addr_q  <= cmd_q[CMD_ADDR_LSB +: ADDR_W];
                    cnt_q   <= cmd_q[LEN_LSB +: LEN_W];
                    op_q    <= cmd_q[OP_BIT];
                    wfill_q <= fill_q;
                    acc_q   <= '0;
                    state_q <= ST_XFER;
                end
                ST_XFER: begin
                    if (rd_vld_q) begin
                        acc_q <= acc_q + ram_rdata;
                    end
                    addr_q <= addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (&addr_q) begin
                            wrap_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Final read word arrives now; fold it straight into the result.
                    if (!op_q) begin
                        data_q <= acc_q + ram_rdata;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status_c          = '0;
        status_c[SB_BUSY] = busy_q;
        status_c[SB_DONE] = done_sticky_q;
        status_c[SB_ERR]  = err_q;
        status_c[SB_WRAP] = wrap_q;
    end

    always_comb begin
        rdata = '0;
        if (sreg_en) begin
            rdata = status_c;
        end else if (dreg_en) begin
            rdata = data_q;
        end
    end

    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_device_mem_ctrl.sv
// Directed self-checking bench for device_mem_ctrl.
module tb_device_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        adreg_ld;
    logic        wdata_ld;
    logic        start;
    logic        sreg_en;
    logic        dreg_en;
    logic        clr;
    logic [15:0] host_data;
    logic [15:0] rdata;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    device_mem_ctrl #(
        .DATA_W (16),
        .ADDR_W (8),
        .LEN_W  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adreg_ld  (adreg_ld),
        .wdata_ld  (wdata_ld),
        .start     (start),
        .sreg_en   (sreg_en),
        .dreg_en   (dreg_en),
        .clr       (clr),
        .host_data (host_data),
        .rdata     (rdata),
        .done      (done),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic s, input logic d, output logic [15:0] v);
        sreg_en = s;
        dreg_en = d;
        #1;
        v = rdata;
        sreg_en = 1'b0;
        dreg_en = 1'b0;
        #1;
    endtask

    task automatic load_regs(input logic op, input logic [7:0] a, input logic [3:0] len,
                             input logic [15:0] fill);
        wdata_ld  = 1'b1;
        host_data = fill;
        step();
        wdata_ld  = 1'b0;
        adreg_ld  = 1'b1;
        host_data = {3'b000, op, len, a};
        step();
        adreg_ld  = 1'b0;
    endtask

    // Launches one operation; lat is the cycle index (start edge = 0) of the done pulse.
    task automatic run_op(input logic op, input logic [7:0] a, input logic [3:0] len,
                          input logic [15:0] fill, output int lat,
                          output logic busy1, output logic busy_done);
        load_regs(op, a, len, fill);
        start     = 1'b1;
        lat       = -1;
        busy1     = 1'b0;
        busy_done = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) busy1 = busy;
            if (done) begin
                lat       = i;
                busy_done = busy;
                break;
            end
        end
        start = 1'b0;
        step();
    endtask

    task automatic checksum(input logic [7:0] a, input logic [3:0] len, output int lat,
                            output logic [15:0] v);
        logic b1, bd;
        run_op(1'b0, a, len, 16'h0000, lat, b1, bd);
        read_reg(1'b0, 1'b1, v);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst = 1'b1; adreg_ld = 0; wdata_ld = 0; start = 0;
        sreg_en = 0; dreg_en = 0; clr = 0; host_data = '0;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", v); end
        read_reg(1'b0, 1'b1, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", v); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fill_checksum();
        int lat;
        logic b1, bd;
        logic [15:0] v;
        run_op(1'b1, 8'h10, 4'd3, 16'hA5A5, lat, b1, bd);
        checks++; if (lat !== 7) begin failures++; $display("FAIL fill_latency got=%0d exp=7", lat); end
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL fill_busy_setup got=%b exp=1", b1); end
        checks++; if (bd !== 1'b0) begin failures++; $display("FAIL fill_busy_done got=%b exp=0", bd); end
        checksum(8'h10, 4'd3, lat, v);
        checks++; if (lat !== 7) begin failures++; $display("FAIL csum_latency got=%0d exp=7", lat); end
        checks++; if (v !== 16'h9694) begin failures++; $display("FAIL csum_4xA5A5 got=%h exp=9694", v); end
        checksum(8'h13, 4'd0, lat, v);
        checks++; if (lat !== 4) begin failures++; $display("FAIL csum1_latency got=%0d exp=4", lat); end
        checks++; if (v !== 16'hA5A5) begin failures++; $display("FAIL word_0x13 got=%h exp=a5a5", v); end
    endtask

    task automatic test_wrap();
        int lat;
        logic b1, bd;
        logic [15:0] v;
        clr = 1'b1; step(); clr = 1'b0;
        run_op(1'b1, 8'hFE, 4'd3, 16'h1234, lat, b1, bd);
        checksum(8'hFE, 4'd3, lat, v);
        checks++; if (v !== 16'h48D0) begin failures++; $display("FAIL wrap_csum got=%h exp=48d0", v); end
        checksum(8'h01, 4'd0, lat, v);
        checks++; if (v !== 16'h1234) begin failures++; $display("FAIL wrap_word_0x01 got=%h exp=1234", v); end
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h000A) begin failures++; $display("FAIL wrap_status got=%h exp=000a", v); end
        clr = 1'b1; step(); clr = 1'b0;
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL clr_status got=%h exp=0000", v); end
    endtask

    task automatic test_start_hold();
        int pulses;
        logic [15:0] v;
        clr = 1'b1;
        load_regs(1'b1, 8'h80, 4'd0, 16'h5A5A);
        clr = 1'b0;
        pulses = 0;
        start  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) pulses++;
        end
        start = 1'b0;
        step();
        checks++; if (pulses !== 1) begin failures++; $display("FAIL hold_done_pulses got=%0d exp=1", pulses); end
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h0002) begin failures++; $display("FAIL hold_status got=%h exp=0002", v); end
    endtask

    task automatic test_restart_while_busy();
        int lat;
        logic [15:0] v;
        clr = 1'b1;
        load_regs(1'b1, 8'h90, 4'd7, 16'h0101);
        clr   = 1'b0;
        start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        step();
        start = 1'b1;
        lat   = -1;
        for (int i = 5; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat !== 11) begin failures++; $display("FAIL restart_latency got=%0d exp=11", lat); end
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h0004) begin failures++; $display("FAIL restart_status_done got=%h exp=0004", v); end
        clr = 1'b1; step(); clr = 1'b0;
        read_reg(1'b1, 1'b0, v);
        checks++; if (v !== 16'h0002) begin failures++; $display("FAIL clr_in_done got=%h exp=0002", v); end
        start = 1'b0;
        step();
        checksum(8'h90, 4'd7, lat, v);
        checks++; if (v !== 16'h0808) begin failures++; $display("FAIL restart_fill_csum got=%h exp=0808", v); end
    endtask

    task automatic test_read_mux();
        logic [15:0] v;
        read_reg(1'b1, 1'b1, v);
        checks++; if (v !== 16'h0002) begin failures++; $display("FAIL mux_both got=%h exp=0002", v); end
        read_reg(1'b0, 1'b0, v);
        checks++; if (v !== 16'h0000) begin failures++; $display("FAIL mux_none got=%h exp=0000", v); end
        read_reg(1'b0, 1'b1, v);
        checks++; if (v !== 16'h0808) begin failures++; $display("FAIL mux_data got=%h exp=0808", v); end
    endtask

    task automatic test_reset_mid_xfer();
        int lat;
        logic b1, bd;
        logic [15:0] v;
        run_op(1'b1, 8'h40, 4'd15, 16'h1111, lat, b1, bd);
        load_regs(1'b1, 8'h40, 4'd15, 16'h2222);
        start = 1'b1;
        for (int i = 0; i < 6; i++) step();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_next busy=%b done=%b exp=0/0", busy, done);
        end
        rst = 1'b0;
        step();
        checksum(8'h40, 4'd15, lat, v);
        checks++; if (v !== 16'h5554) begin failures++; $display("FAIL rst_mid_csum got=%h exp=5554", v); end
        checksum(8'h43, 4'd0, lat, v);
        checks++; if (v !== 16'h2222) begin failures++; $display("FAIL rst_mid_word_0x43 got=%h exp=2222", v); end
        checksum(8'h44, 4'd0, lat, v);
        checks++; if (v !== 16'h1111) begin failures++; $display("FAIL rst_mid_word_0x44 got=%h exp=1111", v); end
    endtask

    initial begin
        test_reset();
        test_fill_checksum();
        test_wrap();
        test_start_hold();
        test_restart_while_busy();
        test_read_mux();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/device_mem_ctrl.md
# device_mem_ctrl

Device-side memory engine sitting directly downstream of the host controller FSM. It consumes the host's strobes (address-register load, start, status/data register read enables, status clear), runs a multi-cycle block transfer against an internal single-port synchronous RAM, and returns a one-cycle `done` pulse that the host turns into an interrupt. Supported operations are block fill (write a constant word) and block checksum (read and sum words).

## Interface
Parameters:
- `DATA_W`, 16: word width of RAM, host data bus and registers.
- `ADDR_W`, 8: RAM address width; depth is 2^ADDR_W.
- `LEN_W`, 4: length field width; a transfer moves `len+1` words, so 1 to 2^LEN_W words.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `adreg_ld`, in, 1: level; while high, load the command register from `host_data`.
- `wdata_ld`, in, 1: level; while high, load the fill-data register from `host_data`.
- `start`, in, 1: level from the host, held high until the host returns to idle. Only the rising edge triggers an operation.
- `sreg_en`, in, 1: drive the status register on `rdata`.
- `dreg_en`, in, 1: drive the data register on `rdata`.
- `clr`, in, 1: clear the sticky status bits.
- `host_data`, in, DATA_W: command or fill word.
- `rdata`, out, DATA_W: combinational read mux.
- `done`, out, 1: registered one-cycle completion pulse.
- `busy`, out, 1: registered; high while a transfer is in progress.

## Operation
- Command word fields: [ADDR_W-1:0] = addr, [ADDR_W+LEN_W-1:ADDR_W] = len, bit [ADDR_W+LEN_W] = op (0 = checksum, 1 = fill). Bits above these are ignored. The default parameters use 13 of 16 bits; DATA_W ≥ ADDR_W+LEN_W+1 is required.
- Start detection: `start_q` registers `start`. An operation is accepted on `start & ~start_q` in IDLE.
  - A rising edge in any other state is ignored and sets err.
- FSM states and transitions:
  - IDLE → SETUP on an accepted start.
  - SETUP → XFER: latch the command into working registers, set count = len, clear the accumulator.
  - XFER: issue one RAM access per cycle at `addr+i` (mod 2^ADDR_W). Leave after the count reaches 0.
  - XFER → DRAIN: the last read word is accumulated.
  - DRAIN → DONE.
  - DONE → IDLE.
- Checksum: data register = sum of the words, mod 2^DATA_W (carry discarded). The data register updates once, at the DRAIN→DONE edge.
- Fill: write the fill register to each address. The data register is unchanged.
- Status register (other bits 0):
  - bit 0: busy.
  - bit 1: done_sticky.
  - bit 2: err.
  - bit 3: wrap. Set when the address increment crosses 2^ADDR_W-1 → 0.
- `clr` clears bits 1–3. If `clr` and a set event occur in the same cycle, the set wins.
- `rdata` selection:
  - `sreg_en` → status register; it takes priority when `sreg_en` and `dreg_en` are both high.
  - otherwise `dreg_en` → data register.
  - otherwise 0.
- Register loads (`adreg_ld`, `wdata_ld`) while busy update the staging registers only. They never affect the transfer in flight.

## Timing
- Reset values:
  - State IDLE; `done`, `busy` = 0; `rdata` = 0 (no enables).
  - Command, fill, data and status registers all 0; `start_q` = 0.
  - RAM contents are not reset.
- Latency, with the rising edge of `start` sampled at the end of cycle 0 and N = len+1:
  - SETUP in cycle 1.
  - XFER in cycles 2 through N+1.
  - DRAIN in cycle N+2.
  - `done` = 1 in cycle N+3 only.
- `busy` = 1 in cycles 1 through N+2. It is 0 in the DONE cycle.
- RAM read latency is 1 cycle. The accumulate trails the address by 1 cycle, and DRAIN covers the final word.
- Reset mid-operation: return to IDLE immediately. Any further RAM writes are suppressed. `done` is not asserted.
- After DONE, a new operation needs `start` low for at least 1 cycle, then high again.

## Structure
- Shared package `dmc_pkg`: state encoding localparams, command field offsets, and status bit indices.
- One sub-module, `dmc_sram`: single-port synchronous RAM with `we`, `addr`, `wdata`, registered `rdata`, and no reset.

## Test plan
- Fill, then checksum (same region):
  - Load fill 0xA5A5; command op=1, addr=0x10, len=3; start. `done` goes high exactly 7 cycles after the start edge, and RAM 0x10–0x13 = 0xA5A5.
  - Then checksum on the same region: data register = 0x9694 (4×0xA5A5 mod 2^16).
  - Read back with `dreg_en`.
- Wrap-around: fill addr=0xFE, len=3, then checksum. Addresses touched are 0xFE, 0xFF, 0x00, 0x01. Status bit 3 = 1. `clr` returns status to 0x0000.
- Start handling:
  - Hold `start` high for 20 cycles → exactly one `done` pulse.
  - A second rising edge while busy → err = 1 and the current op completes normally.
  - `clr` asserted in the DONE cycle → done_sticky still set.
- Reset during XFER of a 16-word fill: `busy`/`done` = 0 next cycle. The words after the reset point keep their prior values.
- Read mux: with `sreg_en` and `dreg_en` both high, `rdata` = status. With neither high, `rdata` = 0.
